spi_aes_frame_master: RTL and testbench
=======================================

Name: spi_aes_frame_master

Overview:
- SPI master that drives one complete encryption transaction into the SPI-attached AES encrypt block.
- Serialises a 49-byte request frame: 16 plaintext bytes, 32 key bytes, 1 key-size byte.
- Waits for the cipher to settle, then clocks 16 ciphertext bytes back in.
- Sits between the host/system logic and the encrypt block's SPI pins.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period (>=2)
- BYTE_GAP, 8, idle clk cycles after every byte, sclk low, cs_n held low
- CIPHER_WAIT, 64, extra idle clk cycles after byte 48 before the first RX byte

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- plaintext  in  128  block to encrypt; byte 0 = [127:120]
- key  in  256  key, left-justified; 128-bit key in [255:128], 192-bit key in [255:64]
- key_len  in  2  0=128, 1=192, 2=256, 3=illegal
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse; ciphertext valid
- err  out  1  one-cycle pulse on rejected start
- ciphertext  out  128  captured result; RX byte 0 lands in [127:120]
- sclk  out  1  SPI clock, mode 0, idle low
- cs_n  out  1  chip select, active low
- mosi  out  1  serial out, MSB first
- miso  in  1  serial in, MSB first

Behaviour:
- Reset values: busy=0, done=0, err=0, ciphertext=0, sclk=0, cs_n=1, mosi=0. All counters cleared, FSM to IDLE.
- Reset mid-frame aborts immediately. cs_n is high the cycle after reset is sampled.
- Accepting start: in IDLE with start=1 and key_len!=3, latch plaintext, key and key_len into a 392-bit shift register.
  - Frame order: plaintext, then key[255:0], then param byte.
  - Param byte: 0x10 for key_len=0, 0x18 for 1, 0x20 for 2.
  - cs_n falls and busy rises on the next clk.
- Rejected start: start with key_len==3 in IDLE gives err=1 for one cycle. Nothing else changes.
- start while busy is ignored; no err.
- States: IDLE -> SETUP -> TX_BIT -> TX_GAP -> (TX_BIT | CWAIT) -> RX_BIT -> RX_GAP -> (RX_BIT | FINISH) -> IDLE.
  - SETUP: CLK_DIV cycles with cs_n low and sclk low; mosi presents the MSB of byte 0.
  - TX_BIT: 8 sclk periods.
    - sclk rises after CLK_DIV cycles low and falls after CLK_DIV cycles high.
    - mosi changes only on the clk after an sclk fall.
    - miso is sampled on the clk where sclk rises.
  - TX_GAP: BYTE_GAP cycles. Byte counter 0..48; after byte 48's gap go to CWAIT.
  - CWAIT: CIPHER_WAIT cycles, cs_n low, mosi=0.
  - RX_BIT: transmits 0x00 while shifting miso into ciphertext MSB-first.
  - RX_GAP: BYTE_GAP cycles. RX byte counter 0..15; after byte 15's gap go to FINISH.
  - FINISH: cs_n=1 and busy=0 in the same cycle; done=1 on the following cycle.
- Ciphertext register updates only during RX_BIT. It holds its value until the next accepted frame's first RX bit.
- Cycle count: from cs_n fall to cs_n rise = CLK_DIV + 65*(16*CLK_DIV + BYTE_GAP) + CIPHER_WAIT. With defaults that is 4748 clk.
- Counter widths must hold byte index 0..48, bit index 0..7 and the largest of CLK_DIV, BYTE_GAP and CIPHER_WAIT. No wrap occurs within a frame.

Optional Feature:
- Macro: SPI_AES_FRAME_MASTER_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 while busy: next cycle cs_n=1, sclk=0, mosi=0, busy=0, FSM to IDLE.
  - err pulses one cycle; no done; ciphertext keeps its old value.
  - abort in IDLE has no effect.
- Undefined: port absent; frames always run to completion.

Test Plan:
- Reset check: assert reset 3 cycles, including one mid-frame -> all outputs at reset values, cs_n=1 on the next clk, no done.
- FIPS-197 AES-128 vector: plaintext=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f followed by 16 zero bytes, key_len=0, SPI slave model returns 69c4e0d86a7b0430d8cdb78070b4c55a.
  - mosi bytes: 00,11..ff, 00,01..0f, sixteen 00, then 0x10.
  - ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a; done after exactly 4748 cycles of cs_n low.
- key_len=1 and key_len=2 -> byte 48 on mosi is 0x18 and 0x20 respectively; all 32 key bytes are sent unchanged.
- key_len=3 with start -> err high 1 cycle, cs_n stays 1, busy stays 0.
- start pulsed every cycle during a frame -> exactly one frame; the next frame starts only after done.
- With SPI_AES_FRAME_MASTER_ABORT_EN defined: abort at TX byte 20 -> cs_n high next clk, err pulse, no done, ciphertext unchanged. A following start completes normally.

Source files
------------

// File: rtl/spi_aes_frame_master.sv
// SPI mode-0 master: sends a 49-byte AES request (plaintext, key, key-size byte), waits, reads 16 ciphertext bytes.
// Optional SPI_AES_FRAME_MASTER_ABORT_EN adds an i_abort input that cancels a frame in flight.
module spi_aes_frame_master #(
  parameter int CLK_DIV     = 4,
  parameter int BYTE_GAP    = 8,
  parameter int CIPHER_WAIT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [127:0] i_plaintext,
  input  logic [255:0] i_key,
  input  logic [1:0]   i_key_len,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic [127:0] o_ciphertext,
  output logic         o_sclk,
  output logic         o_cs_n,
  output logic         o_mosi,
  input  logic         i_miso
`ifdef SPI_AES_FRAME_MASTER_ABORT_EN
  , input logic        i_abort
`endif
);
  localparam int M1   = (2*CLK_DIV > BYTE_GAP) ? 2*CLK_DIV : BYTE_GAP;
  localparam int CMAX = (M1 > CIPHER_WAIT) ? M1 : CIPHER_WAIT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_BIT  = CW'(2*CLK_DIV - 1);
  localparam logic [CW-1:0] C_GAP  = CW'(BYTE_GAP - 1);
  localparam logic [CW-1:0] C_WAIT = CW'(CIPHER_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_TX_BIT, S_TX_GAP, S_CWAIT, S_RX_BIT, S_RX_GAP, S_FINISH
  } state_t;

  state_t         r_state;
  logic [391:0]   r_sh;
  logic [127:0]   r_ct;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_bit;
  logic [5:0]     r_byte;
  logic           r_busy, r_done, r_err, r_sclk, r_cs_n, r_mosi;
  logic [7:0]     w_param;
  logic           w_tx;

  always_comb begin
    case (i_key_len)
      2'd0:    w_param = 8'h10;
      2'd1:    w_param = 8'h18;
      default: w_param = 8'h20;
    endcase
  end

  assign w_tx = (r_state == S_SETUP) || (r_state == S_TX_BIT) || (r_state == S_TX_GAP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_ct    <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_mosi  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // mosi trails the shift register by one clk, so it moves on the clk after each sclk fall
      r_mosi <= w_tx ? r_sh[391] : 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_key_len == 2'd3) begin
              r_err <= 1'b1;
            end else begin
              r_sh    <= {i_plaintext, i_key, w_param};
              r_mosi  <= i_plaintext[127];
              r_cs_n  <= 1'b0;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_bit   <= '0;
              r_byte  <= '0;
              r_state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (r_cnt == C_HALF) begin
            r_cnt   <= '0;
            r_state <= S_TX_BIT;
          end else r_cnt <= r_cnt + CW'(1);
        end
        S_TX_BIT, S_RX_BIT: begin
          if (r_cnt == C_HALF) begin
            r_sclk <= 1'b1;
            if (r_state == S_RX_BIT) r_ct <= {r_ct[126:0], i_miso};
          end
          if (r_cnt == C_BIT) begin
            r_sclk <= 1'b0;
            r_cnt  <= '0;
            r_bit  <= r_bit + 3'd1;
            if (r_state == S_TX_BIT) r_sh <= {r_sh[390:0], 1'b0};
            if (r_bit == 3'd7) r_state <= (r_state == S_TX_BIT) ? S_TX_GAP : S_RX_GAP;
          end else r_cnt <= r_cnt + CW'(1);
        end
        S_TX_GAP: begin
          if (r_cnt == C_GAP) begin
            r_cnt <= '0;
            if (r_byte == 6'd48) begin
              r_byte  <= '0;
              r_state <= S_CWAIT;
            end else begin
              r_byte  <= r_byte + 6'd1;
              r_state <= S_TX_BIT;
            end
          end else r_cnt <= r_cnt + CW'(1);
        end
        S_CWAIT: begin
          if (r_cnt == C_WAIT) begin
            r_cnt   <= '0;
            r_state <= S_RX_BIT;
          end else r_cnt <= r_cnt + CW'(1);
        end
        S_RX_GAP: begin
          if (r_cnt == C_GAP) begin
            r_cnt <= '0;
            if (r_byte == 6'd15) begin
              r_byte  <= '0;
              r_cs_n  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FINISH;
            end else begin
              r_byte  <= r_byte + 6'd1;
              r_state <= S_RX_BIT;
            end
          end else r_cnt <= r_cnt + CW'(1);
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef SPI_AES_FRAME_MASTER_ABORT_EN
      // placed last so it overrides whatever the state logic scheduled this cycle
      if (i_abort && r_busy) begin
        r_state <= S_IDLE;
        r_cs_n  <= 1'b1;
        r_sclk  <= 1'b0;
        r_mosi  <= 1'b0;
        r_busy  <= 1'b0;
        r_err   <= 1'b1;
        r_ct    <= r_ct;
      end
`endif
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_ciphertext = r_ct;
  assign o_sclk       = r_sclk;
  assign o_cs_n       = r_cs_n;
  assign o_mosi       = r_mosi;
endmodule

// File: tb/tb_spi_aes_frame_master.sv
// Directed bench for spi_aes_frame_master: SPI slave model, FIPS-197 vectors, error, restart and reset cases.
`timescale 1ns/1ps
module tb_spi_aes_frame_master;
  logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [127:0] pt = '0;
  logic [255:0] key = '0;
  logic [1:0]   kl = '0;
  logic         busy, done, err, sclk, cs_n, mosi, miso;
  logic [127:0] ct;
`ifdef SPI_AES_FRAME_MASTER_ABORT_EN
  logic         abort = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_aes_frame_master dut (
    .clk(clk), .reset(reset), .i_start(start), .i_plaintext(pt), .i_key(key), .i_key_len(kl),
    .o_busy(busy), .o_done(done), .o_err(err), .o_ciphertext(ct),
    .o_sclk(sclk), .o_cs_n(cs_n), .o_mosi(mosi), .i_miso(miso)
`ifdef SPI_AES_FRAME_MASTER_ABORT_EN
    , .i_abort(abort)
`endif
  );

  typedef struct {
    logic [127:0] pt;
    logic [255:0] key;
    logic [1:0]   kl;
    logic [7:0]   param;
    logic [127:0] resp;
    logic         exp_err;
  } vec_t;
  vec_t vt[4];

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [519:0] act, input logic [519:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // SPI slave model: records mosi at each sclk rise, serves resp MSB-first after 392 TX bits
  int           rise_cnt = 0, low_cnt = 0, cs_falls = 0, done_cnt = 0, err_cnt = 0;
  logic [519:0] mosi_cap = '0;
  logic [127:0] resp = '0;
  logic         prev_sclk = 1'b0, prev_cs_n = 1'b1;

  assign miso = (rise_cnt >= 392 && rise_cnt < 520) ? resp[519 - rise_cnt] : 1'b0;

  always @(negedge clk) begin
    if (cs_n === 1'b0 && prev_cs_n === 1'b1) begin
      rise_cnt = 0;
      low_cnt  = 0;
      mosi_cap = '0;
      cs_falls++;
    end
    if (cs_n === 1'b0) low_cnt++;
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      if (rise_cnt < 520) mosi_cap[519 - rise_cnt] = mosi;
      rise_cnt++;
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    prev_sclk = sclk;
    prev_cs_n = cs_n;
  end

  task automatic run_frame(input int i, input logic spam);
    int d0, f0, e0;
    logic seen;
    pt = vt[i].pt; key = vt[i].key; kl = vt[i].kl; resp = vt[i].resp;
    d0 = done_cnt; f0 = cs_falls; e0 = err_cnt;
    start = 1'b1;
    tick();
    if (!spam) start = 1'b0;
    chk("accept_cs_busy", {cs_n, busy}, 2'b01);
    seen = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      tick();
      if (cs_n) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    chk("frame_end_timeout", seen, 1'b1);
    chk("finish_busy_done", {busy, done}, 2'b00);
    chk("cs_low_cycles", low_cnt, 4748);
    chk("mosi_frame", mosi_cap, {vt[i].pt, vt[i].key, vt[i].param, 128'h0});
    chk("param_byte", mosi_cap[135:128], vt[i].param);
    chk("sclk_rises", rise_cnt, 520);
    tick();
    chk("done_pulse", done, 1'b1);
    chk("ciphertext", ct, vt[i].resp);
    tick();
    chk("done_once", done_cnt - d0, 1);
    chk("single_frame", cs_falls - f0, 1);
    chk("no_err", err_cnt - e0, 0);
  endtask

  task automatic run_err(input int i);
    int e0, f0;
    pt = vt[i].pt; key = vt[i].key; kl = vt[i].kl;
    e0 = err_cnt; f0 = cs_falls;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_pulse", {err, cs_n, busy}, 3'b110);
    tick();
    chk("err_after", {err, cs_n, busy}, 3'b010);
    chk("err_count", err_cnt - e0, 1);
    chk("err_no_frame", cs_falls - f0, 0);
  endtask

  initial begin
    int d0;
    vt[0] = '{128'h00112233445566778899aabbccddeeff,
              {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 2'd0, 8'h10,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0};
    vt[1] = '{128'h00112233445566778899aabbccddeeff,
              {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 2'd1, 8'h18,
              128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1'b0};
    vt[2] = '{128'h00112233445566778899aabbccddeeff,
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 2'd2, 8'h20,
              128'h8ea2b7ca516745bfeafc49904b496089, 1'b0};
    vt[3] = '{128'hffeeddccbbaa99887766554433221100, 256'h0, 2'd3, 8'h00, 128'h0, 1'b1};

    reset = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", {busy, done, err, sclk, cs_n, mosi}, 6'b000010);
    chk("reset_ciphertext", ct, 128'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      if (vt[i].exp_err) run_err(i);
      else run_frame(i, 1'b0);
    end

    // start held high through a whole frame must still yield exactly one frame
    run_frame(2, 1'b1);
    run_frame(0, 1'b0);

`ifdef SPI_AES_FRAME_MASTER_ABORT_EN
    begin
      logic [127:0] ct_old;
      int e0;
      logic hit;
      ct_old = ct;
      pt = vt[2].pt; key = vt[2].key; kl = vt[2].kl; resp = vt[2].resp;
      start = 1'b1;
      tick();
      start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        tick();
        if (rise_cnt > 160) begin hit = 1'b1; break; end
      end
      chk("abort_reach_byte20", hit, 1'b1);
      d0 = done_cnt; e0 = err_cnt;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_outputs", {cs_n, sclk, mosi, busy, err}, 5'b10001);
      tick();
      chk("abort_err_once", {err, cs_n}, 2'b01);
      repeat (20) tick();
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_err_count", err_cnt - e0, 1);
      chk("abort_ct_kept", ct, ct_old);
      run_frame(1, 1'b0);
    end
`endif

    // reset in the middle of a frame
    pt = vt[1].pt; key = vt[1].key; kl = vt[1].kl; resp = vt[1].resp;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();
    chk("midframe_active", {cs_n, busy}, 2'b01);
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    chk("midreset_outputs", {busy, done, err, sclk, cs_n, mosi}, 6'b000010);
    chk("midreset_ciphertext", ct, 128'h0);
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("midreset_no_done", done_cnt - d0, 0);
    chk("midreset_idle", {cs_n, busy}, 2'b10);
    run_frame(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
